// File: rtl/adder_pkg.sv
// Shared encodings for the adder datapath: result modes and accumulator FSM states.
package adder_pkg;

  typedef enum logic [1:0] {
    MODE_UNS  = 2'b00,
    MODE_ONES = 2'b01,
    MODE_TWOS = 2'b10,
    MODE_RSVD = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ACCUM = 2'b01,
    ST_HOLD  = 2'b10
  } state_e;

  // The reserved encoding behaves as unsigned.
  function automatic logic mode_is_signed(input logic [1:0] mode);
    case (mode)
      MODE_ONES, MODE_TWOS: return 1'b1;
      default:              return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/adder_operand_ext.sv
// Extends one adder result to accumulator width according to its encoding.
// Ones-complement negatives are shifted by one so that -0 maps to zero.
module adder_operand_ext
  import adder_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int ACC_WIDTH = 8
) (
  input  logic [1:0]           mode,
  input  logic [WIDTH-1:0]     y,
  output logic [ACC_WIDTH-1:0] ext
);

  logic [WIDTH-1:0] w_ones_fix;

  assign w_ones_fix = y + WIDTH'(1);

  // Encoding-dependent extension
  always_comb begin
    ext = '0;
    case (mode)
      MODE_TWOS: ext = ACC_WIDTH'($signed(y));
      MODE_ONES: begin
        if (y[WIDTH-1]) begin
          ext = ACC_WIDTH'($signed(w_ones_fix));
        end else begin
          ext = ACC_WIDTH'(y);
        end
      end
      default:   ext = ACC_WIDTH'(y);
    endcase
  end

endmodule

// File: rtl/adder_acc.sv
// Frame accumulator: sums COUNT adder results per frame and holds the sum for handoff.
// Define ADDER_ACC_SAT_EN to clamp on overflow instead of wrapping.
module adder_acc
  import adder_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int ACC_WIDTH = 8,
  parameter int COUNT     = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           mode_i,
  input  logic [WIDTH-1:0]     y_i,
  input  logic                 y_valid_i,
  output logic                 y_ready_o,
  output logic [ACC_WIDTH-1:0] sum_o,
  output logic                 ovf_o,
  output logic                 sum_valid_o,
  input  logic                 sum_ready_i
);

  localparam int            CW       = $clog2(COUNT + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(COUNT);
`ifdef ADDER_ACC_SAT_EN
  localparam logic [ACC_WIDTH-1:0] SMIN = ACC_WIDTH'(1) << (ACC_WIDTH - 1);
  localparam logic [ACC_WIDTH-1:0] SMAX = ~SMIN;
`endif

  state_e               r_state;
  logic [1:0]           r_mode;
  logic [ACC_WIDTH-1:0] r_acc;
  logic [CW-1:0]        r_cnt;
  logic                 r_ovf_acc;
  logic [ACC_WIDTH-1:0] r_sum;
  logic                 r_ovf;
  logic                 r_sum_valid;
  logic                 r_ready;
`ifdef ADDER_ACC_SAT_EN
  logic                 r_sat;
`endif

  logic [1:0]           w_mode;
  logic [ACC_WIDTH-1:0] w_ext;
  logic [ACC_WIDTH:0]   w_sum_full;
  logic                 w_add_ovf;
  logic [ACC_WIDTH-1:0] w_acc_next;
  logic [CW-1:0]        w_cnt_next;
  logic                 w_accept;

  // The first sample of a frame is extended with the live mode, later ones with the latched mode
  always_comb begin
    if (r_state == ST_IDLE) begin
      w_mode = mode_i;
    end else begin
      w_mode = r_mode;
    end
  end

  adder_operand_ext #(
    .WIDTH    (WIDTH),
    .ACC_WIDTH(ACC_WIDTH)
  ) u_ext (
    .mode(w_mode),
    .y   (y_i),
    .ext (w_ext)
  );

  assign w_accept   = y_valid_i & r_ready;
  assign w_sum_full = {1'b0, r_acc} + {1'b0, w_ext};
  assign w_cnt_next = r_cnt + CW'(1);

  // Per-add overflow: carry-out when unsigned, same-sign operands flipping sign when signed
  always_comb begin
    w_add_ovf = 1'b0;
    if (mode_is_signed(r_mode)) begin
      w_add_ovf = (r_acc[ACC_WIDTH-1] == w_ext[ACC_WIDTH-1]) &&
                  (w_sum_full[ACC_WIDTH-1] != r_acc[ACC_WIDTH-1]);
    end else begin
      w_add_ovf = w_sum_full[ACC_WIDTH];
    end
  end

  // Next accumulator value; a clamped frame stays frozen at its limit
  always_comb begin
    w_acc_next = w_sum_full[ACC_WIDTH-1:0];
`ifdef ADDER_ACC_SAT_EN
    if (r_sat) begin
      w_acc_next = r_acc;
    end else if (w_add_ovf) begin
      if (!mode_is_signed(r_mode)) begin
        w_acc_next = '1;
      end else if (r_acc[ACC_WIDTH-1]) begin
        w_acc_next = SMIN;
      end else begin
        w_acc_next = SMAX;
      end
    end else begin
      w_acc_next = w_sum_full[ACC_WIDTH-1:0];
    end
`endif
  end

  // Frame FSM with registered handshake and result outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_mode      <= 2'b00;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_ovf_acc   <= 1'b0;
      r_sum       <= '0;
      r_ovf       <= 1'b0;
      r_sum_valid <= 1'b0;
      r_ready     <= 1'b1;
`ifdef ADDER_ACC_SAT_EN
      r_sat       <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_mode    <= mode_i;
            r_acc     <= w_ext;
            r_cnt     <= CW'(1);
            r_ovf_acc <= 1'b0;
`ifdef ADDER_ACC_SAT_EN
            r_sat     <= 1'b0;
`endif
            if (COUNT == 1) begin
              r_sum       <= w_ext;
              r_ovf       <= 1'b0;
              r_sum_valid <= 1'b1;
              r_ready     <= 1'b0;
              r_state     <= ST_HOLD;
            end else begin
              r_state <= ST_ACCUM;
            end
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_ACCUM: begin
          if (w_accept) begin
            r_acc     <= w_acc_next;
            r_cnt     <= w_cnt_next;
            r_ovf_acc <= r_ovf_acc | w_add_ovf;
`ifdef ADDER_ACC_SAT_EN
            if (w_add_ovf) begin
              r_sat <= 1'b1;
            end else begin
              r_sat <= r_sat;
            end
`endif
            if (w_cnt_next == LAST_CNT) begin
              r_sum       <= w_acc_next;
              r_ovf       <= r_ovf_acc | w_add_ovf;
              r_sum_valid <= 1'b1;
              r_ready     <= 1'b0;
              r_state     <= ST_HOLD;
            end else begin
              r_state <= ST_ACCUM;
            end
          end else begin
            r_state <= ST_ACCUM;
          end
        end
        ST_HOLD: begin
          if (sum_ready_i) begin
            r_sum_valid <= 1'b0;
            r_ready     <= 1'b1;
            r_cnt       <= '0;
            r_state     <= ST_IDLE;
          end else begin
            r_state <= ST_HOLD;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_sum_valid <= 1'b0;
          r_ready     <= 1'b1;
          r_cnt       <= '0;
        end
      endcase
    end
  end

  assign y_ready_o   = r_ready;
  assign sum_o       = r_sum;
  assign ovf_o       = r_ovf;
  assign sum_valid_o = r_sum_valid;

endmodule

// File: tb/tb_adder_acc.sv
// Bench for adder_acc: two instances (ACC_WIDTH 8 and 5) share stimulus; an integer
// model pushes expected frame results to a queue that a negedge monitor drains.
module tb_adder_acc;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] mode_i;
  logic [3:0] y_i;
  logic       y_valid_i;
  logic       sum_ready_i;

  logic       y_ready_o, ovf_o, sum_valid_o;
  logic [7:0] sum_o;
  logic       y5_ready_o, ovf5_o, sum5_valid_o;
  logic [4:0] sum5_o;

  always #5 clk = ~clk;

  adder_acc #(.WIDTH(4), .ACC_WIDTH(8), .COUNT(4)) dut (
    .clk(clk), .rst_n(rst_n), .mode_i(mode_i), .y_i(y_i), .y_valid_i(y_valid_i),
    .y_ready_o(y_ready_o), .sum_o(sum_o), .ovf_o(ovf_o), .sum_valid_o(sum_valid_o),
    .sum_ready_i(sum_ready_i));

  adder_acc #(.WIDTH(4), .ACC_WIDTH(5), .COUNT(4)) dut5 (
    .clk(clk), .rst_n(rst_n), .mode_i(mode_i), .y_i(y_i), .y_valid_i(y_valid_i),
    .y_ready_o(y5_ready_o), .sum_o(sum5_o), .ovf_o(ovf5_o), .sum_valid_o(sum5_valid_o),
    .sum_ready_i(sum_ready_i));

  typedef struct {
    logic [7:0] sum8;
    logic       ovf8;
    logic [4:0] sum5;
    logic       ovf5;
  } exp_t;

  exp_t       exp_q[$];
  int         n_checks = 0;
  int         n_pass   = 0;
  int         m_cnt    = 0;
  logic [1:0] m_mode   = 2'b00;
  int         m_vals[4];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic int sval(input logic [1:0] m, input logic [3:0] y);
    logic [3:0] inv;
    inv = ~y;
    case (m)
      2'b01:   return y[3] ? -int'(inv) : int'(y);
      2'b10:   return y[3] ? int'(y) - 16 : int'(y);
      default: return int'(y);
    endcase
  endfunction

  // Frame sum as plain integers, checked against the representable range after each add
  function automatic void fold(input logic [1:0] m, input int aw, output int sum, output bit ovf);
    bit sg;
    int lo, hi, acc, s;
    bit sat;
    sg  = (m == 2'b01) || (m == 2'b10);
    lo  = sg ? -(1 << (aw - 1)) : 0;
    hi  = sg ? (1 << (aw - 1)) - 1 : (1 << aw) - 1;
    acc = m_vals[0];
    sat = 1'b0;
    ovf = 1'b0;
    for (int i = 1; i < 4; i++) begin
      s = acc + m_vals[i];
      if (s < lo || s > hi) begin
        ovf = 1'b1;
`ifdef ADDER_ACC_SAT_EN
        if (!sat) begin
          acc = (s > hi) ? hi : lo;
          sat = 1'b1;
        end
`else
        acc = s & ((1 << aw) - 1);
        if (acc > hi) acc = acc - (1 << aw);
`endif
      end else if (!sat) begin
        acc = s;
      end
    end
    sum = acc;
  endfunction

  task automatic accept_model(input logic [1:0] m, input logic [3:0] y);
    exp_t e;
    int   s8, s5;
    bit   o8, o5;
    if (m_cnt == 0) m_mode = m;
    m_vals[m_cnt] = sval(m_mode, y);
    m_cnt++;
    if (m_cnt == 4) begin
      fold(m_mode, 8, s8, o8);
      fold(m_mode, 5, s5, o5);
      e.sum8 = 8'(s8);
      e.ovf8 = o8;
      e.sum5 = 5'(s5);
      e.ovf5 = o5;
      exp_q.push_back(e);
      m_cnt = 0;
    end
  endtask

  // Drive a sample and hold it until the DUT takes it
  task automatic send(input logic [1:0] m, input logic [3:0] y);
    int budget;
    budget    = 20;
    mode_i    = m;
    y_i       = y;
    y_valid_i = 1'b1;
    while (!y_ready_o && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    if (budget == 0) begin
      n_checks++;
      $error("FAIL accept_timeout observed=ready0 expected=ready1");
    end
    @(posedge clk); #1;
    accept_model(m, y);
  endtask

  task automatic idle(input int n);
    y_valid_i = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic drain();
    int budget;
    budget    = 20;
    y_valid_i = 1'b0;
    while (exp_q.size() != 0 && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    check("drain_queue", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_sum"},   32'(sum_o),        32'd0);
    check({tag, "_ovf"},   32'(ovf_o),        32'd0);
    check({tag, "_valid"}, 32'(sum_valid_o),  32'd0);
    check({tag, "_ready"}, 32'(y_ready_o),    32'd1);
    check({tag, "_sum5"},  32'(sum5_o),       32'd0);
  endtask

  // Output monitor: stability while held, scoreboard compare on each handshake
  logic       prev_hold = 1'b0;
  logic [7:0] prev_sum;
  logic       prev_ovf;
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (sum_valid_o && prev_hold) begin
        check("hold_stable", {23'd0, ovf_o, sum_o}, {23'd0, prev_ovf, prev_sum});
      end
      if (sum_valid_o) begin
        check("valid5_match", 32'(sum5_valid_o), 32'd1);
      end
      if (sum_valid_o && sum_ready_i) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $error("FAIL unexpected_output observed=sum %0h expected=no output", sum_o);
        end else begin
          e = exp_q.pop_front();
          check("sum8", 32'(sum_o),  32'(e.sum8));
          check("ovf8", 32'(ovf_o),  32'(e.ovf8));
          check("sum5", 32'(sum5_o), 32'(e.sum5));
          check("ovf5", 32'(ovf5_o), 32'(e.ovf5));
        end
      end
      prev_hold = sum_valid_o && !sum_ready_i;
      prev_sum  = sum_o;
      prev_ovf  = ovf_o;
    end else begin
      prev_hold = 1'b0;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n       = 1'b0;
    mode_i      = 2'b00;
    y_i         = 4'h0;
    y_valid_i   = 1'b0;
    sum_ready_i = 1'b1;
    #12;
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // unsigned max values
    for (int i = 0; i < 4; i++) send(2'b00, 4'hF);
    drain();
    // twos-complement most negative
    for (int i = 0; i < 4; i++) send(2'b10, 4'h8);
    drain();
    // ones-complement with -0; later modes must be ignored
    send(2'b01, 4'hE);
    send(2'b00, 4'hE);
    send(2'b10, 4'hF);
    send(2'b11, 4'hE);
    drain();
    // reserved mode behaves unsigned, with gaps
    send(2'b11, 4'h3);
    idle(2);
    send(2'b11, 4'h9);
    send(2'b11, 4'hC);
    idle(1);
    send(2'b11, 4'h5);
    drain();

    // backpressure in HOLD with a sample pending
    sum_ready_i = 1'b0;
    send(2'b10, 4'h7);
    send(2'b10, 4'h7);
    send(2'b10, 4'h6);
    send(2'b10, 4'h5);
    mode_i    = 2'b00;
    y_i       = 4'h1;
    y_valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("hold_ready_low", 32'(y_ready_o),   32'd0);
      check("hold_valid",     32'(sum_valid_o), 32'd1);
      @(posedge clk); #1;
    end
    sum_ready_i = 1'b1;
    @(posedge clk); #1;
    check("post_hs_ready", 32'(y_ready_o),   32'd1);
    check("post_hs_valid", 32'(sum_valid_o), 32'd0);
    send(2'b00, 4'h1);
    send(2'b00, 4'h2);
    idle(3);
    send(2'b00, 4'h3);
    send(2'b00, 4'h4);
    drain();

    // reset mid-frame discards partial sums
    send(2'b00, 4'h5);
    send(2'b00, 4'h6);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_accum");
    m_cnt = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    send(2'b00, 4'h2);
    send(2'b00, 4'h3);
    send(2'b00, 4'h4);
    send(2'b00, 4'h5);
    drain();

    // reset while holding discards the held frame
    sum_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) send(2'b10, 4'h3);
    y_valid_i = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_hold");
    exp_q.delete();
    @(posedge clk); #1;
    rst_n       = 1'b1;
    sum_ready_i = 1'b1;
    idle(2);
    check("no_output_after_rst", 32'(sum_valid_o), 32'd0);

    // random frames
    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < 4; i++) begin
        send(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
        if ($urandom_range(0, 3) == 0) idle(1);
      end
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
